// File: rtl/pla_bist_sweep.sv
// pla_bist_sweep: self-test stimulus source and response compactor for a
// 4-in/4-out PLA. Sweeps {A,B,C,D} exhaustively (0..15) or through a
// 15-state LFSR, folds F1..F4 into a 16-bit MISR and compares the result
// against a signature latched at start.
module pla_bist_sweep #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] exp_sig,
  input  logic        F1,
  input  logic        F2,
  input  logic        F3,
  input  logic        F4,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [4:0]  vec_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // Settle counter terminal value; unused when SETTLE is zero.
  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  // With no settle cycles each vector goes straight to its capture cycle.
  localparam state_t     FIRST_ST    = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;

  state_t      state_q, state_d;
  logic [3:0]  vec_q,   vec_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        mode_q,  mode_d;
  logic [15:0] exp_q,   exp_d;
  logic [15:0] sig_q,   sig_d;
  logic [4:0]  vcnt_q,  vcnt_d;
  logic        pass_q,  pass_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;

  logic [15:0] misr_next;
  logic [3:0]  vec_adv;
  logic        last_vec;

  // MISR step, vector advance and end-of-sweep detection.
  always_comb begin
    misr_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000)
              ^ {12'h000, F1, F2, F3, F4};
    vec_adv   = mode_q ? {vec_q[2:0], vec_q[3] ^ vec_q[2]} : vec_q + 4'd1;
    last_vec  = mode_q ? (vec_q == 4'b1000) : (vec_q == 4'b1111);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    vcnt_d  = vcnt_q;
    pass_d  = pass_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          exp_d   = exp_sig;
          sig_d   = '0;
          vcnt_d  = '0;
          pass_d  = 1'b0;
          vec_d   = mode ? 4'b0001 : 4'b0000;
          cnt_d   = '0;
          state_d = FIRST_ST;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CAPTURE: begin
        sig_d  = misr_next;
        vcnt_d = vcnt_q + 5'd1;
        cnt_d  = '0;
        if (last_vec) begin
          // pass is resolved at the final capture edge so it is valid
          // in the same cycle that done rises.
          state_d = ST_DONE;
          vec_d   = '0;
          pass_d  = (misr_next == exp_q);
        end else begin
          state_d = FIRST_ST;
          vec_d   = vec_adv;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      exp_q   <= '0;
      sig_q   <= '0;
      vcnt_q  <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
      vcnt_q  <= vcnt_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {A, B, C, D} = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign signature    = sig_q;
  assign vec_count    = vcnt_q;

endmodule

// File: tb/tb_pla_bist_sweep.sv
// Bench for pla_bist_sweep: two instances (SETTLE=2 and SETTLE=0) share
// stimulus; a cycle-level model derived from sweep timing rules is compared
// against both every cycle, plus literal end-of-sweep expectations.
module tb_pla_bist_sweep;

  localparam int SET [2] = '{2, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i   = 1'b1;
  logic        start_i = 1'b1;
  logic        mode_i  = 1'b0;
  logic [15:0] exp_i   = '0;
  logic        ftype   = 1'b0;
  logic [3:0]  fconst  = 4'b0001;

  logic [1:0][3:0]  abcd;
  logic [1:0][3:0]  f;
  logic [1:0]       busy, done, pass;
  logic [1:0][15:0] sig;
  logic [1:0][4:0]  vc;

  int nchk = 0;
  int nerr = 0;
  bit cmp_en = 1'b0;

  function automatic logic [3:0] pla_fn(input logic [3:0] v);
    return {^v, &v[1:0], v[3] | v[0], ~v[2]};
  endfunction

  assign f[0] = ftype ? pla_fn(abcd[0]) : fconst;
  assign f[1] = ftype ? pla_fn(abcd[1]) : fconst;

  pla_bist_sweep #(.SETTLE(2)) u_s2 (
    .clk(clk), .rst(rst_i), .start(start_i), .mode(mode_i), .exp_sig(exp_i),
    .F1(f[0][3]), .F2(f[0][2]), .F3(f[0][1]), .F4(f[0][0]),
    .A(abcd[0][3]), .B(abcd[0][2]), .C(abcd[0][1]), .D(abcd[0][0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .signature(sig[0]), .vec_count(vc[0])
  );

  pla_bist_sweep #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst_i), .start(start_i), .mode(mode_i), .exp_sig(exp_i),
    .F1(f[1][3]), .F2(f[1][2]), .F3(f[1][1]), .F4(f[1][0]),
    .A(abcd[1][3]), .B(abcd[1][2]), .C(abcd[1][1]), .D(abcd[1][0]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .signature(sig[1]), .vec_count(vc[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // k-th applied vector of a sweep.
  function automatic logic [3:0] vec_of(input bit m, input int unsigned k);
    if (!m) return 4'(k);
    case (k)
      0: return 4'b0001;   1: return 4'b0010;   2: return 4'b0100;
      3: return 4'b1001;   4: return 4'b0011;   5: return 4'b0110;
      6: return 4'b1101;   7: return 4'b1010;   8: return 4'b0101;
      9: return 4'b1011;  10: return 4'b0111;  11: return 4'b1111;
      12: return 4'b1110; 13: return 4'b1100;  default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [3:0] fv);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, fv};
  endfunction

  // Model state: sweep active flag and edges elapsed since the start edge.
  bit          m_act [2];
  bit          m_done[2];
  bit          m_pass[2];
  bit          m_mode[2];
  int unsigned m_t   [2];
  int unsigned m_vc  [2];
  logic [15:0] m_sig [2];
  logic [15:0] m_exp [2];

  initial begin
    int unsigned per, n, k;
    logic [3:0] fv;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        per = SET[i] + 1;
        if (rst_i) begin
          m_act[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_t[i] = 0;
          m_vc[i] = 0;  m_sig[i] = '0; m_mode[i] = 0; m_exp[i] = '0;
          cmp_en = 1'b1;
        end else if (m_act[i]) begin
          m_t[i]++;
          if (m_t[i] % per == 0) begin
            k  = m_t[i] / per - 1;
            fv = ftype ? pla_fn(vec_of(m_mode[i], k)) : fconst;
            m_sig[i] = misr(m_sig[i], fv);
            m_vc[i]++;
          end
          n = m_mode[i] ? 15 : 16;
          if (m_t[i] == n * per) begin
            m_act[i]  = 0;
            m_done[i] = 1;
            m_pass[i] = (m_sig[i] == m_exp[i]);
          end
        end else if (m_done[i]) begin
          m_done[i] = 0;
        end else if (start_i) begin
          m_act[i] = 1; m_t[i] = 0; m_mode[i] = mode_i; m_exp[i] = exp_i;
          m_sig[i] = '0; m_vc[i] = 0; m_pass[i] = 0;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    logic [3:0] ev;
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en) begin
        for (int i = 0; i < 2; i++) begin
          ev = m_act[i] ? vec_of(m_mode[i], m_t[i] / (SET[i] + 1)) : 4'b0000;
          chk($sformatf("s%0d_abcd", SET[i]), abcd[i], ev);
          chk($sformatf("s%0d_busy", SET[i]), busy[i], m_act[i]);
          chk($sformatf("s%0d_done", SET[i]), done[i], m_done[i]);
          chk($sformatf("s%0d_pass", SET[i]), pass[i], m_pass[i]);
          chk($sformatf("s%0d_sig", SET[i]), sig[i], m_sig[i]);
          chk($sformatf("s%0d_vcnt", SET[i]), vc[i], m_vc[i]);
        end
      end
    end
  end

  // kind: 0 plain, 1 extra start at e0+5, 2 reset at e0+20.
  task automatic run(input int inst, input bit m, input logic [15:0] e,
                     input int kind, input int exp_cyc, input bit do_lit,
                     input logic [15:0] l_sig, input int l_vc, input bit l_pass);
    bit found;
    @(posedge clk); #2;
    start_i = 1'b1; mode_i = m; exp_i = e;
    @(posedge clk);   // e0
    #2 start_i = 1'b0;
    found = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #2;
      start_i = (kind == 1 && c == 4);
      if (kind == 2 && c == 19) rst_i = 1'b1;
      if (kind == 2 && c == 20) begin
        rst_i = 1'b0;
        chk("midrst_busy", busy[inst], 1'b0);
        chk("midrst_sig", sig[inst], 16'h0000);
        chk("midrst_vcnt", vc[inst], 5'd0);
        chk("midrst_abcd", abcd[inst], 4'b0000);
        found = 1;
        break;
      end
      if (done[inst]) begin
        found = 1;
        chk("done_cycle", c, exp_cyc);
        if (do_lit) begin
          chk("lit_sig", sig[inst], l_sig);
          chk("lit_vcnt", vc[inst], l_vc);
          chk("lit_pass", pass[inst], l_pass);
        end
        break;
      end
    end
    if (!found) chk("done_timeout", 0, 1);
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (busy == 2'b00 && done == 2'b00) begin
        found = 1;
        break;
      end
    end
    if (!found) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    // Reset held with start asserted: no sweep may begin.
    repeat (2) @(posedge clk);
    #2 rst_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #2;
    chk("rst_busy", busy, 2'b00);
    chk("rst_abcd", abcd, 8'h00);
    chk("rst_sig", sig[0], 16'h0000);
    chk("rst_vcnt", vc[0], 5'd0);
    chk("rst_pass", pass, 2'b00);

    fconst = 4'b0001;
    run(0, 1'b0, 16'hFFFF, 0, 48, 1, 16'hFFFF, 16, 1'b1);
    run(1, 1'b1, 16'h7FFF, 0, 15, 1, 16'h7FFF, 15, 1'b1);

    fconst = 4'b0000;
    run(0, 1'b0, 16'h1234, 0, 48, 1, 16'h0000, 16, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    chk("hold_sig", sig[0], 16'h0000);
    chk("hold_pass", pass[0], 1'b0);
    chk("hold_vcnt", vc[0], 5'd16);

    fconst = 4'b0001;
    run(0, 1'b0, 16'hFFFF, 1, 48, 1, 16'hFFFF, 16, 1'b1);
    run(0, 1'b0, 16'hFFFF, 2, 0, 0, 16'h0000, 0, 1'b0);
    run(0, 1'b0, 16'hFFFF, 0, 48, 1, 16'hFFFF, 16, 1'b1);

    ftype = 1'b1;
    run(0, 1'b1, 16'hBEEF, 0, 45, 0, 16'h0000, 0, 1'b0);
    run(1, 1'b0, 16'h0000, 0, 16, 0, 16'h0000, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
